s100_adr_test_sequencer: RTL and testbench

Bus-cycle sequencer for the T35 S100 address-line test. It steps through a pattern of 20-bit addresses (walking one, walking zero, or an incrementing count) and, for each address, runs one complete S100 bus cycle on pSYNC / pSTVAL / pDBIN / n_pWR. It also sequences the address, status and control output enables. It sits between the board's 2 MHz tick source and the S100 pin drivers, replacing free-running pin toggling with repeatable, scope-triggerable cycles.

---
 rtl/s100_test_pkg.sv | 28 ++
 rtl/s100_adr_pattern_gen.sv | 43 ++++
 rtl/s100_adr_test_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_s100_adr_test_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/s100_test_pkg.sv
// Shared definitions for the T35 S100 address-line test sequencer.
//   seq_state_t       : bus-cycle sequencer states
//   MODE_*            : pattern select codes on the 'mode' input
//   *_IDLE            : pin levels of the S100 strobes when no cycle is active
package s100_test_pkg;

  localparam int unsigned ADR_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENABLE,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_NEXT,
    ST_DISABLE
  } seq_state_t;

  localparam logic [1:0] MODE_WALK1 = 2'b00;
  localparam logic [1:0] MODE_WALK0 = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;

  localparam logic PSYNC_IDLE  = 1'b0;
  localparam logic PSTVAL_IDLE = 1'b1;
  localparam logic PDBIN_IDLE  = 1'b0;
  localparam logic NPWR_IDLE   = 1'b1;

endpackage

// File: rtl/s100_adr_pattern_gen.sv
// Combinational address pattern for the S100 address-line test.
//   step : step index within the run
//   mode : pattern select (walk one / walk zero / count; reserved = walk one)
//   adr  : 20-bit test address for this step
//   last : this step is the final one of the run for this mode
module s100_adr_pattern_gen
  import s100_test_pkg::*;
#(
  parameter int unsigned COUNT_LEN = 256
) (
  input  logic [ADR_W-1:0] step,
  input  logic [1:0]       mode,
  output logic [ADR_W-1:0] adr,
  output logic             last
);

  localparam logic [ADR_W-1:0] WALK_LAST  = ADR_W'(ADR_W - 1);
  localparam logic [ADR_W-1:0] COUNT_LAST = ADR_W'(COUNT_LEN - 1);
  localparam logic [ADR_W-1:0] ADR_ONE    = ADR_W'(1);

  logic [ADR_W-1:0] one_hot;

  always_comb begin
    // Shifts of 20..31 fall off the top and give zero; walking modes never
    // reach them because the run ends at step 19.
    one_hot = ADR_ONE << step[4:0];
    case (mode)
      MODE_WALK0: begin
        adr  = ~one_hot;
        last = (step == WALK_LAST);
      end
      MODE_COUNT: begin
        adr  = step;
        last = (step == COUNT_LAST);
      end
      default: begin
        adr  = one_hot;
        last = (step == WALK_LAST);
      end
    endcase
  end

endmodule

// File: rtl/s100_adr_test_sequencer.sv
// Bus-cycle sequencer for the T35 S100 address-line test.
// Steps through an address pattern and runs one S100 bus cycle
// (T1/T2/T3 on pSYNC/pSTVAL/pDBIN/n_pWR) per address, framed by the
// address/status/control buffer enables.
//   clockIn, reset     : system clock, synchronous active-high reset
//   tick               : one-clock enable that paces every bus-cycle step
//   pll_locked         : low aborts a run back to IDLE with reset outputs
//   start              : level, accepted in IDLE only
//   mode, wr           : pattern select and read/write, latched at run start
//   continuous         : wrap to step 0 after the last step instead of ending
//   S100adr, step      : registered test address and step index
//   pSYNC..n_pWR       : S100 bus strobes
//   F_*_oe             : buffer enables, active high
//   busy, done         : run in progress / one-clock completion pulse
module s100_adr_test_sequencer
  import s100_test_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned COUNT_LEN  = 256
) (
  input  logic             clockIn,
  input  logic             reset,
  input  logic             tick,
  input  logic             pll_locked,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             wr,
  input  logic             continuous,
  output logic [ADR_W-1:0] S100adr,
  output logic             pSYNC,
  output logic             pSTVAL,
  output logic             pDBIN,
  output logic             n_pWR,
  output logic             F_add_oe,
  output logic             F_bus_stat_oe,
  output logic             F_bus_ctl_oe,
  output logic             busy,
  output logic             done,
  output logic [ADR_W-1:0] step
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_TICKS - 1);

  seq_state_t       state, state_nxt;
  logic             abort;
  logic [1:0]       mode_q, mode_d;
  logic             wr_q;
  logic [3:0]       hold_cnt;
  logic             last_q;
  logic             run_start;
  logic             adr_load;
  logic [ADR_W-1:0] step_d;
  logic [ADR_W-1:0] pat_adr;
  logic             pat_last;

  logic psync_d, pstval_d, pdbin_d, npwr_d, oe_d, busy_d, done_d;

  assign abort     = (state != ST_IDLE) && !pll_locked;
  assign run_start = (state == ST_IDLE) && (state_nxt == ST_ENABLE);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clockIn) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start && pll_locked) state_nxt = ST_ENABLE;
        ST_ENABLE:  if (tick) state_nxt = ST_T1;
        ST_T1:      if (tick) state_nxt = ST_T2;
        ST_T2:      if (tick) state_nxt = ST_T3;
        ST_T3:      if (tick && hold_cnt == 4'd0) state_nxt = ST_NEXT;
        ST_NEXT:    if (tick) state_nxt = (!last_q || continuous) ? ST_T1 : ST_DISABLE;
        ST_DISABLE: state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------- step / pattern
  // The generator is fed the step and mode that are about to be registered,
  // so address, step and last-step flag all update on the same edge.
  always_comb begin
    step_d   = step;
    mode_d   = mode_q;
    adr_load = 1'b0;
    if (run_start) begin
      step_d   = '0;
      mode_d   = mode;
      adr_load = 1'b1;
    end else if (state == ST_NEXT && state_nxt == ST_T1) begin
      step_d   = last_q ? '0 : step + ADR_W'(1);
      adr_load = 1'b1;
    end
  end

  s100_adr_pattern_gen #(
    .COUNT_LEN(COUNT_LEN)
  ) u_pattern (
    .step (step_d),
    .mode (mode_d),
    .adr  (pat_adr),
    .last (pat_last)
  );

  always_ff @(posedge clockIn) begin
    if (reset) begin
      step     <= '0;
      S100adr  <= '0;
      last_q   <= 1'b0;
      mode_q   <= MODE_WALK1;
      wr_q     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (abort) begin
        step    <= '0;
        S100adr <= '0;
        last_q  <= 1'b0;
      end else if (adr_load) begin
        step    <= step_d;
        S100adr <= pat_adr;
        last_q  <= pat_last;
      end
      mode_q <= mode_d;
      if (run_start) wr_q <= wr;
      if (state == ST_T2 && tick)
        hold_cnt <= HOLD_LOAD;
      else if (state == ST_T3 && tick && hold_cnt != 4'd0)
        hold_cnt <= hold_cnt - 4'd1;
    end
  end

  // -------------------------------------------------------------- output comb
  // Decoded from the next state and registered below, so pins move on the
  // same edge as the state register.
  always_comb begin
    psync_d  = PSYNC_IDLE;
    pstval_d = PSTVAL_IDLE;
    pdbin_d  = PDBIN_IDLE;
    npwr_d   = NPWR_IDLE;
    oe_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_nxt)
      ST_ENABLE, ST_NEXT: begin
        oe_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_T1: begin
        oe_d     = 1'b1;
        busy_d   = 1'b1;
        psync_d  = 1'b1;
        pstval_d = 1'b1;
      end
      ST_T2: begin
        oe_d     = 1'b1;
        busy_d   = 1'b1;
        psync_d  = 1'b1;
        pstval_d = 1'b0;
      end
      ST_T3: begin
        oe_d     = 1'b1;
        busy_d   = 1'b1;
        psync_d  = 1'b0;
        pstval_d = 1'b1;
        pdbin_d  = !wr_q;
        npwr_d   = !wr_q;
      end
      ST_DISABLE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (reset) begin
      pSYNC         <= PSYNC_IDLE;
      pSTVAL        <= PSTVAL_IDLE;
      pDBIN         <= PDBIN_IDLE;
      n_pWR         <= NPWR_IDLE;
      F_add_oe      <= 1'b0;
      F_bus_stat_oe <= 1'b0;
      F_bus_ctl_oe  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      pSYNC         <= psync_d;
      pSTVAL        <= pstval_d;
      pDBIN         <= pdbin_d;
      n_pWR         <= npwr_d;
      F_add_oe      <= oe_d;
      F_bus_stat_oe <= oe_d;
      F_bus_ctl_oe  <= oe_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_s100_adr_test_sequencer.sv
// Directed self-checking bench for s100_adr_test_sequencer
// (HOLD_TICKS=4, COUNT_LEN=8, tick every 25 clocks).
module tb_s100_adr_test_sequencer;

  localparam int unsigned HOLD = 4;

  // {pSYNC, pSTVAL, pDBIN, n_pWR}
  localparam logic [3:0] SB_T1   = 4'b1101;
  localparam logic [3:0] SB_T2   = 4'b1001;
  localparam logic [3:0] SB_T3R  = 4'b0111;
  localparam logic [3:0] SB_T3W  = 4'b0100;
  localparam logic [3:0] SB_IDLE = 4'b0101;
  // {busy, F_add_oe, F_bus_stat_oe, F_bus_ctl_oe, done}
  localparam logic [4:0] CT_RUN  = 5'b11110;
  localparam logic [4:0] CT_OFF  = 5'b00000;
  localparam logic [4:0] CT_DONE = 5'b10001;

  logic        clockIn = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        pll_locked = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        wr = 1'b0;
  logic        continuous = 1'b0;
  logic [19:0] S100adr;
  logic        pSYNC, pSTVAL, pDBIN, n_pWR;
  logic        F_add_oe, F_bus_stat_oe, F_bus_ctl_oe;
  logic        busy, done;
  logic [19:0] step;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  s100_adr_test_sequencer #(
    .HOLD_TICKS(HOLD),
    .COUNT_LEN (8)
  ) dut (
    .clockIn       (clockIn),
    .reset         (reset),
    .tick          (tick),
    .pll_locked    (pll_locked),
    .start         (start),
    .mode          (mode),
    .wr            (wr),
    .continuous    (continuous),
    .S100adr       (S100adr),
    .pSYNC         (pSYNC),
    .pSTVAL        (pSTVAL),
    .pDBIN         (pDBIN),
    .n_pWR         (n_pWR),
    .F_add_oe      (F_add_oe),
    .F_bus_stat_oe (F_bus_stat_oe),
    .F_bus_ctl_oe  (F_bus_ctl_oe),
    .busy          (busy),
    .done          (done),
    .step          (step)
  );

  always #5 clockIn = ~clockIn;

  initial begin
    forever begin
      repeat (24) @(posedge clockIn);
      #1 tick = 1'b1;
      @(posedge clockIn);
      #1 tick = 1'b0;
    end
  end

  always @(negedge clockIn) if (done) done_cnt++;

  wire [3:0] strb = {pSYNC, pSTVAL, pDBIN, n_pWR};
  wire [4:0] ctl  = {busy, F_add_oe, F_bus_stat_oe, F_bus_ctl_oe, done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic expect_pins(input string tag, input logic [3:0] sb, input logic [4:0] ct,
                             input logic [19:0] adr, input logic [19:0] stp);
    check({tag, ".strb"}, 32'(strb), 32'(sb));
    check({tag, ".ctl"}, 32'(ctl), 32'(ct));
    check({tag, ".adr"}, 32'(S100adr), 32'(adr));
    check({tag, ".step"}, 32'(step), 32'(stp));
  endtask

  // Advance past the next clock edge that carries a tick, sample at negedge.
  task automatic wait_tick();
    for (int i = 0; i < 64; i++) begin
      @(posedge clockIn);
      if (tick) break;
    end
    @(negedge clockIn);
  endtask

  task automatic bus_cycle(input string name, input int k, input logic [19:0] adr,
                           input logic [19:0] stp, input logic w);
    string t;
    t = $sformatf("%s.c%0d", name, k);
    wait_tick(); expect_pins({t, ".T1"}, SB_T1, CT_RUN, adr, stp);
    wait_tick(); expect_pins({t, ".T2"}, SB_T2, CT_RUN, adr, stp);
    for (int h = 0; h < int'(HOLD); h++) begin
      wait_tick(); expect_pins({t, ".T3"}, w ? SB_T3W : SB_T3R, CT_RUN, adr, stp);
    end
    wait_tick(); expect_pins({t, ".NX"}, SB_IDLE, CT_RUN, adr, stp);
  endtask

  task automatic finish_run(input string name, input logic [19:0] adr, input logic [19:0] stp);
    wait_tick();
    expect_pins({name, ".DIS"}, SB_IDLE, CT_DONE, adr, stp);
    @(negedge clockIn);
    check({name, ".idle.strb"}, 32'(strb), 32'(SB_IDLE));
    check({name, ".idle.ctl"}, 32'(ctl), 32'(CT_OFF));
  endtask

  task automatic start_now();
    start = 1'b1;
    @(negedge clockIn);
    start = 1'b0;
  endtask

  logic [19:0] a;
  int          base;

  initial begin
    // ---------------- reset values
    repeat (3) @(posedge clockIn);
    @(negedge clockIn);
    expect_pins("rst", SB_IDLE, CT_OFF, 20'h0, 20'h0);
    reset = 1'b0;
    repeat (3) @(negedge clockIn);
    expect_pins("idle", SB_IDLE, CT_OFF, 20'h0, 20'h0);

    // ---------------- walking one, read; start coincides with a tick
    mode = 2'b00; wr = 1'b0; continuous = 1'b0;
    base = done_cnt;
    @(posedge tick);
    start = 1'b1;
    @(posedge clockIn);
    #1 start = 1'b0;
    @(negedge clockIn);
    expect_pins("w1.EN", SB_IDLE, CT_RUN, 20'h00001, 20'h0);
    for (int k = 0; k < 20; k++) begin
      a = 20'h00001 << k;
      bus_cycle("w1", k, a, 20'(k), 1'b0);
    end
    finish_run("w1", 20'h80000, 20'd19);
    check("w1.done_cnt", 32'(done_cnt), 32'(base + 1));

    // ---------------- walking zero, write; start pulsed and mode/wr changed mid-run
    mode = 2'b01; wr = 1'b1;
    base = done_cnt;
    start_now();
    expect_pins("w0.EN", SB_IDLE, CT_RUN, 20'hFFFFE, 20'h0);
    for (int k = 0; k < 20; k++) begin
      a = ~(20'h00001 << k);
      bus_cycle("w0", k, a, 20'(k), 1'b1);
      if (k == 3) begin
        start = 1'b1; mode = 2'b10; wr = 1'b0;
      end
      if (k == 5) start = 1'b0;
    end
    finish_run("w0", 20'h7FFFF, 20'd19);
    check("w0.done_cnt", 32'(done_cnt), 32'(base + 1));

    // ---------------- count, continuous, then drop continuous
    mode = 2'b10; wr = 1'b0; continuous = 1'b1;
    base = done_cnt;
    start_now();
    expect_pins("cnt.EN", SB_IDLE, CT_RUN, 20'h0, 20'h0);
    for (int k = 0; k < 18; k++) bus_cycle("cnt", k, 20'(k % 8), 20'(k % 8), 1'b0);
    check("cnt.no_done", 32'(done_cnt), 32'(base));
    continuous = 1'b0;
    for (int k = 18; k < 24; k++) bus_cycle("cnt", k, 20'(k % 8), 20'(k % 8), 1'b0);
    finish_run("cnt", 20'h7, 20'h7);
    check("cnt.done_cnt", 32'(done_cnt), 32'(base + 1));

    // ---------------- PLL loss in T2 of step 5
    mode = 2'b00; wr = 1'b0;
    base = done_cnt;
    start_now();
    for (int k = 0; k < 5; k++) bus_cycle("ab", k, 20'h00001 << k, 20'(k), 1'b0);
    wait_tick(); expect_pins("ab.c5.T1", SB_T1, CT_RUN, 20'h00020, 20'd5);
    wait_tick(); expect_pins("ab.c5.T2", SB_T2, CT_RUN, 20'h00020, 20'd5);
    pll_locked = 1'b0;
    @(negedge clockIn);
    expect_pins("ab.idle", SB_IDLE, CT_OFF, 20'h0, 20'h0);
    pll_locked = 1'b1;
    repeat (2) @(negedge clockIn);
    check("ab.no_done", 32'(done_cnt), 32'(base));

    // ---------------- restart, then reset in T3
    start_now();
    expect_pins("rs.EN", SB_IDLE, CT_RUN, 20'h00001, 20'h0);
    wait_tick(); expect_pins("rs.T1", SB_T1, CT_RUN, 20'h00001, 20'h0);
    wait_tick(); expect_pins("rs.T2", SB_T2, CT_RUN, 20'h00001, 20'h0);
    wait_tick(); expect_pins("rs.T3", SB_T3R, CT_RUN, 20'h00001, 20'h0);
    reset = 1'b1;
    @(negedge clockIn);
    expect_pins("rs.reset", SB_IDLE, CT_OFF, 20'h0, 20'h0);
    reset = 1'b0;
    repeat (30) @(negedge clockIn);
    expect_pins("rs.idle", SB_IDLE, CT_OFF, 20'h0, 20'h0);
    check("rs.no_done", 32'(done_cnt), 32'(base));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
